// File: rtl/branch_pkg.sv
// Package: branch_pkg
// Purpose: shared definitions for the branch predictor slice.
//   - CmpEn_J_Off encodings seen on the resolve port.
//   - 2-bit saturating counter states and the reset state.
//   - actual_outcome(): the real direction of a resolving instruction.
// Ports: none (package).
package branch_pkg;

  // Resolve-port instruction class (ResCmpEn_J_Off); 2'b11 is illegal.
  localparam logic [1:0] CMP = 2'b10;
  localparam logic [1:0] JMP = 2'b01;
  localparam logic [1:0] OFF = 2'b00;

  // Counter states: strongly/weakly not-taken, weakly/strongly taken.
  localparam logic [1:0] SNT       = 2'b00;
  localparam logic [1:0] WNT       = 2'b01;
  localparam logic [1:0] WT        = 2'b10;
  localparam logic [1:0] ST        = 2'b11;
  localparam logic [1:0] CNT_RESET = WNT;

  // Real control-flow direction of the resolving instruction.
  // Illegal class 2'b11 behaves like a non-branch.
  function automatic logic actual_outcome(input logic [1:0] cmp_en_j_off,
                                          input logic       res_taken);
    logic a;
    case (cmp_en_j_off)
      CMP:     a = res_taken;
      JMP:     a = 1'b1;
      default: a = 1'b0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Module: sat_counter2
// Purpose: combinational next-state function of a 2-bit saturating counter.
// Ports:
//   i_cur   in  2  current counter value
//   i_taken in  1  training direction (1 = count up, 0 = count down)
//   o_nxt   out 2  next counter value, saturating at 00 and 11
module sat_counter2
  import branch_pkg::*;
(
  input  logic [1:0] i_cur,
  input  logic       i_taken,
  output logic [1:0] o_nxt
);

  // Saturating up/down step.
  always_comb begin
    o_nxt = i_cur;
    case (i_cur)
      SNT:     o_nxt = i_taken ? WNT : SNT;
      WNT:     o_nxt = i_taken ? WT  : SNT;
      WT:      o_nxt = i_taken ? ST  : WNT;
      ST:      o_nxt = i_taken ? ST  : WT;
      default: o_nxt = CNT_RESET;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Module: branch_predictor
// Purpose: PC-indexed table of 2-bit saturating counters giving fetch a
//   taken/not-taken prediction, trained by resolved branches from execute.
//   A misprediction produces a registered one-cycle Flush with RedirectPC.
// Ports:
//   Clk, Rst        clock (rising edge) and synchronous active-high reset
//   FetchPC         PC being fetched
//   PredTaken       prediction for FetchPC (combinational table read)
//   ResValid        execute-stage instruction valid
//   ResPC           PC of the resolving instruction
//   ResCmpEn_J_Off  10 branch, 01 jump, 00 non-branch (11 treated as 00)
//   ResTaken        resolved branch outcome
//   ResPredTaken    prediction that travelled with the instruction
//   ResTarget       computed branch/jump target
//   Flush           one-cycle squash pulse
//   RedirectPC      correct next PC, valid while Flush=1
//   MispredCnt      wrapping misprediction counter
module branch_predictor
  import branch_pkg::*;
#(
  parameter int N        = 32,
  parameter int IDX_BITS = 6
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [N-1:0]  FetchPC,
  output logic          PredTaken,
  input  logic          ResValid,
  input  logic [N-1:0]  ResPC,
  input  logic [1:0]    ResCmpEn_J_Off,
  input  logic          ResTaken,
  input  logic          ResPredTaken,
  input  logic [N-1:0]  ResTarget,
  output logic          Flush,
  output logic [N-1:0]  RedirectPC,
  output logic [31:0]   MispredCnt
);

  localparam int DEPTH = 2 ** IDX_BITS;
  localparam logic [N-1:0] PC_STEP = {{(N-3){1'b0}}, 3'd4};

  logic [1:0]          r_table [DEPTH];
  logic                r_flush;
  logic [N-1:0]        r_redirect;
  logic [31:0]         r_mispred_cnt;

  logic [IDX_BITS-1:0] w_fetch_idx;
  logic [IDX_BITS-1:0] w_res_idx;
  logic                w_eff;
  logic                w_actual;
  logic                w_mispred;
  logic                w_train;
  logic [1:0]          w_cnt_nxt;
  logic                w_unused_fetch;

  // Word-aligned PCs: drop the two byte-offset bits; upper bits alias.
  assign w_fetch_idx    = FetchPC[IDX_BITS+1:2];
  assign w_res_idx      = ResPC[IDX_BITS+1:2];
  assign w_unused_fetch = ^{FetchPC[N-1:IDX_BITS+2], FetchPC[1:0]};

  // Reads the registered table, so a same-cycle update is not visible yet.
  assign PredTaken = r_table[w_fetch_idx][1];

  // A resolve during the Flush cycle belongs to a squashed instruction.
  assign w_eff     = ResValid && !r_flush;
  assign w_actual  = actual_outcome(ResCmpEn_J_Off, ResTaken);
  assign w_mispred = w_eff && (w_actual != ResPredTaken);
  assign w_train   = w_eff && (ResCmpEn_J_Off == CMP);

  sat_counter2 u_sat_counter2 (
    .i_cur   (r_table[w_res_idx]),
    .i_taken (ResTaken),
    .o_nxt   (w_cnt_nxt)
  );

  // Counter table: reset all entries, otherwise train the resolving entry.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= CNT_RESET;
      end
    end else if (w_train) begin
      r_table[w_res_idx] <= w_cnt_nxt;
    end else begin
      r_table[w_res_idx] <= r_table[w_res_idx];
    end
  end

  // Flush pulse, redirect target and misprediction count.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_flush       <= 1'b0;
      r_redirect    <= '0;
      r_mispred_cnt <= 32'd0;
    end else if (w_mispred) begin
      r_flush       <= 1'b1;
      r_redirect    <= w_actual ? ResTarget : (ResPC + PC_STEP);
      r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end else begin
      r_flush       <= 1'b0;
      r_redirect    <= r_redirect;
      r_mispred_cnt <= r_mispred_cnt;
    end
  end

  assign Flush      = r_flush;
  assign RedirectPC = r_redirect;
  assign MispredCnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed vectors, expected values pushed to
// a scoreboard queue tagged with the cycle they apply to; a monitor on the
// falling edge pops and compares them.
module tb_branch_predictor;
  import branch_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] FetchPC;
  logic        PredTaken;
  logic        ResValid;
  logic [31:0] ResPC;
  logic [1:0]  ResCmpEn_J_Off;
  logic        ResTaken;
  logic        ResPredTaken;
  logic [31:0] ResTarget;
  logic        Flush;
  logic [31:0] RedirectPC;
  logic [31:0] MispredCnt;

  branch_predictor #(.N(32), .IDX_BITS(6)) dut (
    .Clk(Clk), .Rst(Rst), .FetchPC(FetchPC), .PredTaken(PredTaken),
    .ResValid(ResValid), .ResPC(ResPC), .ResCmpEn_J_Off(ResCmpEn_J_Off),
    .ResTaken(ResTaken), .ResPredTaken(ResPredTaken), .ResTarget(ResTarget),
    .Flush(Flush), .RedirectPC(RedirectPC), .MispredCnt(MispredCnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          cyc;
    string       name;
    int          kind;   // 0 PredTaken, 1 Flush, 2 RedirectPC, 3 MispredCnt
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          m_cnt = 0;
  logic [31:0] m_redir = 32'd0;

  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [31:0] dut_val(input int kind);
    case (kind)
      0:       return {31'd0, PredTaken};
      1:       return {31'd0, Flush};
      2:       return RedirectPC;
      default: return MispredCnt;
    endcase
  endfunction

  // Monitor: compare every expectation due in this cycle.
  always @(negedge Clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
      exp_t e;
      logic [31:0] act;
      e = sb_q.pop_front();
      act = dut_val(e.kind);
      n_checks++;
      if (e.cyc != cyc_cnt || act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, due %0d)",
                 e.name, act, e.val, cyc_cnt, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input string nm, input int kind, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc_cnt; e.name = nm; e.kind = kind; e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic push_state(input string nm, input logic fl, input logic pa);
    push({nm, "_flush"}, 1, {31'd0, fl});
    push({nm, "_redir"}, 2, m_redir);
    push({nm, "_cnt"},   3, m_cnt);
    push({nm, "_pred"},  0, {31'd0, pa});
  endtask

  task automatic drive(input logic [31:0] pc, input logic [1:0] cmp,
                       input logic tk, input logic pt, input logic [31:0] tgt);
    ResValid = 1'b1; ResPC = pc; ResCmpEn_J_Off = cmp;
    ResTaken = tk; ResPredTaken = pt; ResTarget = tgt;
  endtask

  // One resolve issued while Flush=0; pb/pa are PredTaken(FetchPC) before
  // and after the update; fl/rd are the expected flush and redirect.
  task automatic do_res(input string nm, input logic [31:0] pc,
                        input logic [1:0] cmp, input logic tk, input logic pt,
                        input logic [31:0] tgt, input logic pb,
                        input logic fl, input logic [31:0] rd, input logic pa);
    drive(pc, cmp, tk, pt, tgt);
    push({nm, "_pred_old"}, 0, {31'd0, pb});
    step();
    ResValid = 1'b0;
    if (fl) begin
      m_cnt++;
      m_redir = rd;
    end
    push_state(nm, fl, pa);
    step();
    push({nm, "_flush_end"}, 1, 32'd0);
  endtask

  initial begin
    Rst = 1'b1; FetchPC = 32'h40; ResValid = 1'b0; ResPC = 32'd0;
    ResCmpEn_J_Off = OFF; ResTaken = 1'b0; ResPredTaken = 1'b0; ResTarget = 32'd0;
    step();
    step();
    push_state("reset", 1'b0, 1'b0);
    Rst = 1'b0;

    // Training at 0x40; FetchPC==ResPC so the old bit is seen in the update cycle.
    do_res("t1",  32'h40, CMP, 1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1); // 01->10
    do_res("t2",  32'h40, CMP, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1); // 10->11
    do_res("t3",  32'h40, CMP, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1); // 11->11
    do_res("t4",  32'h40, CMP, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0,   1'b1); // 11, correct
    do_res("s1",  32'h40, CMP, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h44,  1'b1); // 11->10
    do_res("s2",  32'h40, CMP, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h44,  1'b0); // 10->01
    do_res("s3",  32'h40, CMP, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0,   1'b0); // 01->00
    do_res("s4",  32'h40, CMP, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0,   1'b0); // 00->00
    do_res("s5",  32'h40, CMP, 1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 32'h100, 1'b0); // 00->01
    do_res("s6",  32'h40, CMP, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   1'b1); // 01->10

    // Jump and non-branch never train (ResTaken=1 would raise the counter).
    FetchPC = 32'h80;
    do_res("jmp", 32'h80, JMP, 1'b1, 1'b0, 32'h200, 1'b0, 1'b1, 32'h200, 1'b0);
    FetchPC = 32'h84;
    do_res("off", 32'h84, OFF, 1'b1, 1'b1, 32'h300, 1'b0, 1'b1, 32'h88,  1'b0);
    do_res("ill", 32'h84, 2'b11, 1'b1, 1'b0, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
    FetchPC = 32'h40;

    // Resolve during Flush is ignored (counter 10->11 only once).
    drive(32'h40, CMP, 1'b1, 1'b0, 32'h100);
    step();
    m_cnt++; m_redir = 32'h100;
    push("fc_flush", 1, 32'd1);
    drive(32'h40, CMP, 1'b0, 1'b1, 32'h500);
    step();
    ResValid = 1'b0;
    push_state("fc_ign", 1'b0, 1'b1);
    step();
    do_res("fc_n1", 32'h40, CMP, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h44,  1'b1); // 11->10
    do_res("fc_n2", 32'h40, CMP, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h44,  1'b0); // 10->01
    do_res("pre_r", 32'h40, CMP, 1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1); // 01->10

    // Reset in the same cycle as a mispredict wins.
    Rst = 1'b1;
    drive(32'h40, CMP, 1'b1, 1'b0, 32'h100);
    step();
    Rst = 1'b0; ResValid = 1'b0;
    m_cnt = 0; m_redir = 32'd0;
    push_state("rst_m", 1'b0, 1'b0);
    step();

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge Clk);
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end of test");
    $fatal(1, "timeout");
  end

endmodule
